// File: rtl/micro_inst_encoder.sv
// Macro-to-micro instruction encoder: each accepted instruction is expanded into 1-3 micro-instructions.
// Optional feature: define MENC_ILLEGAL_TRAP_EN to trap illegal opcodes instead of encoding them as NOP.
module micro_inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [43:0] minstr_out,
    output logic        minstr_valid,
    input  logic        minstr_ready,
    output logic        minstr_last,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

    typedef struct packed {
        logic [4:0] opcode;
        logic       imm_f;
        logic [3:0] dst;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [7:0] imm;
    } instr_t;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_BR   = 5'h10;
    localparam logic [4:0] OP_CBR  = 5'h11;

    state_t state_q, state_d;
    instr_t instr_q, instr_d;
    instr_t instr_fields;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[13:8];

    function automatic logic is_alu(input logic [4:0] op);
        return (op >= 5'h01) && (op <= 5'h07);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op == OP_NOP) || is_alu(op) || (op == OP_BR) || (op == OP_CBR);
    endfunction

    assign instr_fields = '{opcode: instr_in[31:27], imm_f: instr_in[26], dst: instr_in[25:22],
                            src1: instr_in[21:18], src2: instr_in[17:14], imm: instr_in[7:0]};

    assign instr_ready  = (state_q == IDLE);
    assign minstr_valid = (state_q != IDLE);

`ifdef MENC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
`ifdef MENC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_fields;
`ifdef MENC_ILLEGAL_TRAP_EN
                    if (!is_legal(instr_fields.opcode)) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S1;
                    end
`else
                    state_d = S1;
`endif
                end
            end
            S1: if (minstr_ready) state_d = is_alu(instr_q.opcode) ? S2 : IDLE;
            S2: if (minstr_ready) state_d = S3;
            S3: if (minstr_ready) state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state and fields, so they stay stable while stalled.
    always_comb begin
        minstr_out  = '0;
        minstr_last = 1'b0;
        unique case (state_q)
            IDLE: ;
            S1: begin
                if (is_alu(instr_q.opcode)) begin
                    minstr_out[40:36] = {1'b0, instr_q.src1};
                    minstr_out[0]     = 1'b1;
                    minstr_out[4]     = 1'b1;
                end else begin
                    minstr_last = 1'b1;
                    if (instr_q.opcode == OP_BR) begin
                        minstr_out[43:41] = 3'b100;
                        minstr_out[17:10] = instr_q.imm;
                    end else if (instr_q.opcode == OP_CBR) begin
                        minstr_out[43:41] = 3'b011;
                        minstr_out[40:36] = {1'b0, instr_q.src1};
                        minstr_out[27:20] = instr_q.imm;
                        minstr_out[17:10] = instr_q.imm;
                    end
                end
            end
            S2: begin
                minstr_out[8] = 1'b1;
                if (instr_q.imm_f) begin
                    minstr_out[43:41] = 3'b001;
                    minstr_out[27:20] = instr_q.imm;
                end else begin
                    minstr_out[40:36] = {1'b0, instr_q.src2};
                    minstr_out[4]     = 1'b1;
                end
            end
            S3: begin
                minstr_out[35:31] = {1'b0, instr_q.dst};
                minstr_out[3:1]   = instr_q.opcode[2:0];
                minstr_out[4]     = 1'b1;
                minstr_out[5]     = 1'b1;
                minstr_last       = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

`ifdef MENC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
`endif

endmodule
